// File: rtl/div_ctrl_pkg.sv
// Shared types and default widths for the divider issue controller.
//
// Contents:
//   *_DEF      default widths, latency and FIFO depth
//   div_req_t  one divide request {dividend, divisor}
//   div_tag_t  sideband travelling next to the divider {valid, id, dbz}
//   div_resp_t one buffered result {id, dbz, quotient, remainder}
//
// The structs are sized at the default widths. div_issue_ctrl builds its own
// copies at its actual parameter values so that it can be re-parameterised.
package div_ctrl_pkg;

    localparam int unsigned DIVIDENDLEN_DEF = 16;
    localparam int unsigned DIVISORLEN_DEF  = 8;
    localparam int unsigned PIPE_LAT_DEF    = 16;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;

    typedef struct packed {
        logic [DIVIDENDLEN_DEF-1:0] dividend;
        logic [DIVISORLEN_DEF-1:0]  divisor;
    } div_req_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic dbz;
    } div_tag_t;

    typedef struct packed {
        logic                       id;
        logic                       dbz;
        logic [DIVIDENDLEN_DEF-1:0] quotient;
        logic [DIVISORLEN_DEF-1:0]  remainder;
    } div_resp_t;

endpackage

// File: rtl/div_resp_fifo.sv
// Response FIFO sitting behind the divider.
//
// Parameters:
//   DEPTH    number of entries, power of two and >= 2
//   entry_t  stored type (defaults to div_resp_t)
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   push/push_data  write one entry
//   pop             drop the head entry
//   pop_data        head entry (held in a register, zero after reset)
//   empty/full      occupancy flags
//
// Push and pop may coincide at any occupancy. Pointers wrap naturally because
// DEPTH is a power of two.
module div_resp_fifo
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = FIFO_DEPTH_DEF,
    parameter type         entry_t = div_resp_t
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   empty,
    output logic   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller and round-robin arbiter in front of a fixed-latency,
// non-stallable pipelined divider shared by two requesters.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   reqN_valid/ready              request handshake for requester N (0, 1)
//   reqN_dividend/divisor         operands, held stable until accepted
//   div_dividend/divisor          operands into divider stage 0 (zero when idle)
//   div_quotient/remainder        divider final-stage result
//   resp_valid/ready              response handshake (FIFO head)
//   resp_id/dbz/quotient/remainder head entry contents
//   stat_issued/completed/dbz     16-bit wrapping counters, present only when
//                                 DIVCTRL_STATS_EN is defined
//
// Requester ID and divide-by-zero travel in a sideband shift register matched
// to the divider latency. Credits equal the FIFO depth, so a result leaving the
// divider always finds a free FIFO slot.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIVIDENDLEN = DIVIDENDLEN_DEF,
    parameter int unsigned DIVISORLEN  = DIVISORLEN_DEF,
    parameter int unsigned PIPE_LAT    = PIPE_LAT_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [DIVIDENDLEN-1:0] req0_dividend,
    input  logic [DIVISORLEN-1:0]  req0_divisor,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [DIVIDENDLEN-1:0] req1_dividend,
    input  logic [DIVISORLEN-1:0]  req1_divisor,
    output logic [DIVIDENDLEN-1:0] div_dividend,
    output logic [DIVISORLEN-1:0]  div_divisor,
    input  logic [DIVIDENDLEN-1:0] div_quotient,
    input  logic [DIVISORLEN-1:0]  div_remainder,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic                   resp_dbz,
    output logic [DIVIDENDLEN-1:0] resp_quotient,
    output logic [DIVISORLEN-1:0]  resp_remainder
`ifdef DIVCTRL_STATS_EN
    ,
    output logic [15:0]            stat_issued,
    output logic [15:0]            stat_completed,
    output logic [15:0]            stat_dbz
`endif
);

    localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                   id;
        logic                   dbz;
        logic [DIVIDENDLEN-1:0] quotient;
        logic [DIVISORLEN-1:0]  remainder;
    } resp_t;

    logic [CRW-1:0] credits_q;
    logic [CRW-1:0] credits_d;
    logic           last_gnt_q;   // requester granted on the most recent issue
    div_tag_t       tag_q [PIPE_LAT];

    logic  gnt0;
    logic  gnt1;
    logic  issue;
    logic  issue_dbz;
    logic  pop;
    logic  push;
    logic  fifo_empty;
    logic  fifo_full;
    resp_t push_data;
    resp_t head;

    // Arbitration: a lone requester wins; on contention the one not granted last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (credits_q != '0) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign issue      = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        div_dividend = '0;
        div_divisor  = '0;
        if (gnt0) begin
            div_dividend = req0_dividend;
            div_divisor  = req0_divisor;
        end else if (gnt1) begin
            div_dividend = req1_dividend;
            div_divisor  = req1_divisor;
        end
    end

    // Zero divisors still go down the pipe; their result is replaced at the tail.
    assign issue_dbz = issue && (div_divisor == '0);

    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - CRW'(1);
        end else if (pop && !issue) begin
            credits_d = credits_q + CRW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q      <= '{default: '0};
            last_gnt_q <= 1'b1;
            credits_q  <= CRW'(FIFO_DEPTH);
        end else begin
            tag_q[0] <= '{valid: issue, id: gnt1, dbz: issue_dbz};
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (issue) begin
                last_gnt_q <= gnt1;
            end
            credits_q <= credits_d;
        end
    end

    // Tail: merge the sideband with the divider result.
    assign push = tag_q[PIPE_LAT-1].valid;

    always_comb begin
        push_data.id        = tag_q[PIPE_LAT-1].id;
        push_data.dbz       = tag_q[PIPE_LAT-1].dbz;
        push_data.quotient  = div_quotient;
        push_data.remainder = div_remainder;
        if (tag_q[PIPE_LAT-1].dbz) begin
            push_data.quotient  = '1;
            push_data.remainder = '0;
        end
    end

    div_resp_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (resp_t)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign resp_valid     = ~fifo_empty;
    assign pop            = resp_valid & resp_ready;
    assign resp_id        = head.id;
    assign resp_dbz       = head.dbz;
    assign resp_quotient  = head.quotient;
    assign resp_remainder = head.remainder;

    // Credit accounting must make this impossible.
    push_never_full : assert property (@(posedge clock) disable iff (reset)
        !(push && fifo_full));

`ifdef DIVCTRL_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_completed_q;
    logic [15:0] stat_dbz_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued_q    <= '0;
            stat_completed_q <= '0;
            stat_dbz_q       <= '0;
        end else begin
            if (issue) begin
                stat_issued_q <= stat_issued_q + 16'd1;
            end
            if (pop) begin
                stat_completed_q <= stat_completed_q + 16'd1;
            end
            if (pop && head.dbz) begin
                stat_dbz_q <= stat_dbz_q + 16'd1;
            end
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_completed = stat_completed_q;
    assign stat_dbz       = stat_dbz_q;
`endif

endmodule
